// File: rtl/pulse_train_generator_pkg.sv
// Shared definitions for the pulse train generator: default field widths and
// the sequencer state encoding, also reused by the LCD command FSM.
package pulse_train_generator_pkg;

    localparam int PTG_CNT_W = 16;
    localparam int PTG_N_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_GAP    = 2'd3
    } ptg_state_e;

endpackage

// File: rtl/pulse_train_generator_if.sv
// Trigger/configuration/status bundle between a requester and the pulse train generator.
interface pulse_train_generator_if
    import pulse_train_generator_pkg::*;
#(
    parameter int CNT_W = PTG_CNT_W,
    parameter int N_W   = PTG_N_W
) ();

    logic             i_trigger;
    logic [CNT_W-1:0] i_delay;
    logic [CNT_W-1:0] i_width;
    logic [CNT_W-1:0] i_gap;
    logic [N_W-1:0]   i_count;
    logic             o_pulse;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_trigger, i_delay, i_width, i_gap, i_count,
        input  o_pulse, o_busy, o_done
    );

    modport slave (
        input  i_trigger, i_delay, i_width, i_gap, i_count,
        output o_pulse, o_busy, o_done
    );

endinterface

// File: rtl/pulse_down_counter.sv
// Loadable down-counter that saturates at 1, with a registered flag marking
// the cycle in which the count equals 1 (the last cycle of a timed phase).
module pulse_down_counter
    import pulse_train_generator_pkg::*;
#(
    parameter int CNT_W = PTG_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             terminal
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             terminal_q;
    logic             terminal_d;

    // Next count: load wins, otherwise step down but never below 1.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q > CNT_W'(1))) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
        terminal_d = (count_d == CNT_W'(1));
    end

    // Count and terminal flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q    <= CNT_W'(0);
            terminal_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            terminal_q <= terminal_d;
        end
    end

    assign terminal = terminal_q;

endmodule

// File: rtl/pulse_train_generator.sv
// Turns a one-cycle trigger into an optional start delay followed by N pulses
// of programmable width separated by programmable gaps; all outputs registered.
module pulse_train_generator
    import pulse_train_generator_pkg::*;
#(
    parameter int   CNT_W      = PTG_CNT_W,
    parameter int   N_W        = PTG_N_W,
    parameter logic ACTIVE_LVL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    pulse_train_generator_if.slave bus
);

    ptg_state_e       state_q, state_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] gap_q,   gap_d;
    logic [N_W-1:0]   rem_q,   rem_d;
    logic             pulse_q, pulse_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_val_s;
    logic             cnt_en_s;
    logic             cnt_term_s;

    function automatic logic [CNT_W-1:0] nz_cnt(input logic [CNT_W-1:0] v);
        nz_cnt = (v == CNT_W'(0)) ? CNT_W'(1) : v;
    endfunction

    function automatic logic [N_W-1:0] nz_n(input logic [N_W-1:0] v);
        nz_n = (v == N_W'(0)) ? N_W'(1) : v;
    endfunction

    // One shared phase timer, reloaded with the new phase length on every state entry.
    pulse_down_counter #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .en       (cnt_en_s),
        .terminal (cnt_term_s)
    );

    assign cnt_en_s = (state_q != ST_IDLE);

    // Next-state, config capture and timer reload; outputs follow the next state
    // so the first pulse can appear one cycle after the trigger.
    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        gap_d      = gap_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        cnt_load_s = 1'b0;
        cnt_val_s  = CNT_W'(0);
        case (state_q)
            ST_IDLE: begin
                if (bus.i_trigger) begin
                    width_d    = nz_cnt(bus.i_width);
                    gap_d      = nz_cnt(bus.i_gap);
                    rem_d      = nz_n(bus.i_count);
                    cnt_load_s = 1'b1;
                    if (bus.i_delay != CNT_W'(0)) begin
                        state_d   = ST_DELAY;
                        cnt_val_s = bus.i_delay;
                    end else begin
                        state_d   = ST_ACTIVE;
                        cnt_val_s = nz_cnt(bus.i_width);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DELAY: begin
                if (cnt_term_s) begin
                    state_d    = ST_ACTIVE;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = width_q;
                end else begin
                    state_d = ST_DELAY;
                end
            end
            ST_ACTIVE: begin
                if (cnt_term_s) begin
                    rem_d = rem_q - N_W'(1);
                    if (rem_q > N_W'(1)) begin
                        state_d    = ST_GAP;
                        cnt_load_s = 1'b1;
                        cnt_val_s  = gap_q;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_GAP: begin
                if (cnt_term_s) begin
                    state_d    = ST_ACTIVE;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = width_q;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pulse_d = (state_d == ST_ACTIVE) ? ACTIVE_LVL : ~ACTIVE_LVL;
        busy_d  = (state_d != ST_IDLE);
    end

    // State, captured configuration and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            width_q <= CNT_W'(0);
            gap_q   <= CNT_W'(0);
            rem_q   <= N_W'(0);
            pulse_q <= ~ACTIVE_LVL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            gap_q   <= gap_d;
            rem_q   <= rem_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_pulse = pulse_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench: two generators (active-high and active-low) driven alike and
// compared every cycle against an arithmetic model of the waveform timing.
module tb_pulse_train_generator;

    logic        clk = 1'b0;
    logic        rst_v;
    logic        trig;
    logic [15:0] delay_v, width_v, gap_v;
    logic [7:0]  count_v;
    logic        chk_en = 1'b0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    pulse_train_generator_if #(.CNT_W(16), .N_W(8)) if_a ();
    pulse_train_generator_if #(.CNT_W(16), .N_W(8)) if_b ();

    assign if_a.i_trigger = trig;
    assign if_a.i_delay   = delay_v;
    assign if_a.i_width   = width_v;
    assign if_a.i_gap     = gap_v;
    assign if_a.i_count   = count_v;
    assign if_b.i_trigger = trig;
    assign if_b.i_delay   = delay_v;
    assign if_b.i_width   = width_v;
    assign if_b.i_gap     = gap_v;
    assign if_b.i_count   = count_v;

    pulse_train_generator #(.CNT_W(16), .N_W(8), .ACTIVE_LVL(1'b1)) dut_a (
        .clk(clk), .rst(rst_v), .bus(if_a));
    pulse_train_generator #(.CNT_W(16), .N_W(8), .ACTIVE_LVL(1'b0)) dut_b (
        .clk(clk), .rst(rst_v), .bus(if_b));

    task automatic check(input string nm, input int cyc, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%b expected=%b", nm, cyc, act, exp);
        end
    endtask

    // Reference model: the accepted sequence described by its start cycle and effective D, W, G, N.
    logic   m_valid = 1'b0;
    longint m_t0, m_d, m_w, m_g, m_n;
    longint mc = 0;

    always @(negedge clk) begin : model_cmp
        longint r, last;
        logic   e_busy, e_act, e_done;
        r      = mc - m_t0;
        last   = m_d + m_n * m_w + (m_n - 1) * m_g;
        e_busy = m_valid && (r >= 1) && (r <= last);
        e_done = m_valid && (r == last + 1);
        e_act  = e_busy && (r >= 1 + m_d) && (((r - 1 - m_d) % (m_w + m_g)) < m_w);
        if (chk_en) begin
            check("model_pulse_hi", int'(mc), if_a.o_pulse, e_act);
            check("model_pulse_lo", int'(mc), if_b.o_pulse, ~e_act);
            check("model_busy",     int'(mc), if_a.o_busy && if_b.o_busy, e_busy);
            check("model_done",     int'(mc), if_a.o_done || if_b.o_done, e_done);
            check("model_busy_agree", int'(mc), if_a.o_busy ^ if_b.o_busy, 1'b0);
        end
        if (!rst_v) begin
            m_valid = 1'b0;
        end else if (trig && !e_busy) begin
            m_valid = 1'b1;
            m_t0    = mc;
            m_d     = longint'(delay_v);
            m_w     = (width_v == 16'd0) ? 64'd1 : longint'(width_v);
            m_g     = (gap_v   == 16'd0) ? 64'd1 : longint'(gap_v);
            m_n     = (count_v == 8'd0)  ? 64'd1 : longint'(count_v);
        end
        mc++;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles from a trigger at k=0, checking hand-computed per-cycle bit masks.
    task automatic run_table(input string nm, input logic [15:0] d, input logic [15:0] w,
                             input logic [15:0] g, input logic [7:0] n, input int ncyc,
                             input logic [63:0] pm, input logic [63:0] bm, input logic [63:0] dm,
                             input logic [63:0] tm, input logic [63:0] rm,
                             input int wchg, input logic [15:0] wnew);
        delay_v = d; width_v = w; gap_v = g; count_v = n;
        for (int k = 0; k < ncyc; k++) begin
            trig  = tm[k];
            rst_v = ~rm[k];
            if (k == wchg) width_v = wnew;
            @(negedge clk);
            check({nm, "_pulse_hi"}, k, if_a.o_pulse, pm[k]);
            check({nm, "_pulse_lo"}, k, if_b.o_pulse, ~pm[k]);
            check({nm, "_busy"},     k, if_a.o_busy,  bm[k]);
            check({nm, "_done"},     k, if_a.o_done,  dm[k]);
            next_cycle();
        end
        trig  = 1'b0;
        rst_v = 1'b1;
    endtask

    task automatic idle(input int n);
        trig = 1'b0;
        repeat (n) next_cycle();
    endtask

    initial begin
        rst_v = 1'b0; trig = 1'b0;
        delay_v = 16'd0; width_v = 16'd0; gap_v = 16'd0; count_v = 8'd0;
        repeat (3) next_cycle();
        check("reset_pulse_hi", 0, if_a.o_pulse, 1'b0);
        check("reset_pulse_lo", 0, if_b.o_pulse, 1'b1);
        check("reset_busy",     0, if_a.o_busy || if_b.o_busy, 1'b0);
        check("reset_done",     0, if_a.o_done || if_b.o_done, 1'b0);
        rst_v  = 1'b1;
        chk_en = 1'b1;
        idle(2);

        run_table("minimal", 16'd0, 16'd1, 16'd1, 8'd1, 5,
                  64'h2, 64'h2, 64'h4, 64'h1, 64'h0, -1, 16'd0);
        idle(3);
        run_table("zero_sub", 16'd0, 16'd0, 16'd0, 8'd0, 5,
                  64'h2, 64'h2, 64'h4, 64'h1, 64'h0, -1, 16'd0);
        idle(3);
        run_table("train", 16'd3, 16'd4, 16'd2, 8'd3, 23,
                  64'h000F3CF0, 64'h000FFFFE, 64'h00100000, 64'h1, 64'h0, -1, 16'd0);
        idle(3);
        // Trigger at 5 and width change at 6 are ignored; trigger at the done cycle is accepted.
        run_table("retrig", 16'd3, 16'd4, 16'd2, 8'd3, 26,
                  64'h030F3CF0, 64'h03EFFFFE, 64'h00100000, 64'h00100021, 64'h0, 6, 16'd9);
        idle(45);
        run_table("rst_mid", 16'd3, 16'd4, 16'd2, 8'd3, 26,
                  64'h033C0CF0, 64'h03FF8FFE, 64'h0, 64'h00004001, 64'h00000800, -1, 16'd0);
        idle(20);
        run_table("inverted", 16'd2, 16'd5, 16'd0, 8'd1, 10,
                  64'hF8, 64'hFE, 64'h100, 64'h1, 64'h0, -1, 16'd0);
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            rst_v   = ($urandom_range(99) != 0);
            trig    = ($urandom_range(5) == 0);
            delay_v = 16'($urandom_range(5));
            width_v = 16'($urandom_range(4));
            gap_v   = 16'($urandom_range(4));
            count_v = 8'($urandom_range(4));
            next_cycle();
        end
        rst_v = 1'b1;
        idle(80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
